lsu_ctrl: RTL and testbench

- Multi-cycle load/store controller directly downstream of the execute ALU.
- Accepts one memory op per handshake: load/store opcodes 19–26, effective address, store data.
- Drives a variable-latency data-memory port with a req/ack handshake.
- Returns aligned, sign/zero-extended load data to writeback, or completes the store.

---
 rtl/lsu_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store controller between execute and a req/ack data memory.
// Optional macro LSU_MISALIGN_SPLIT_EN enables misaligned and word-crossing accesses.
module lsu_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    localparam logic [5:0] OP_LB  = 6'd19;
    localparam logic [5:0] OP_LH  = 6'd20;
    localparam logic [5:0] OP_LW  = 6'd21;
    localparam logic [5:0] OP_LBU = 6'd22;
    localparam logic [5:0] OP_LHU = 6'd23;
    localparam logic [5:0] OP_SB  = 6'd24;
    localparam logic [5:0] OP_SH  = 6'd25;
    localparam logic [5:0] OP_SW  = 6'd26;

    localparam bit          TMO_EN   = (TIMEOUT != 0);
    localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(TIMEOUT - 1) : 32'd0;

    function automatic logic [2:0] op_size(input logic [5:0] o);
        case (o)
            OP_LB, OP_LBU, OP_SB: op_size = 3'd1;
            OP_LH, OP_LHU, OP_SH: op_size = 3'd2;
            default:              op_size = 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] s);
        case (s)
            3'd1:    size_mask = 4'b0001;
            3'd2:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    // Shift the two-word window down by the byte offset, then trim and extend.
    function automatic logic [31:0] load_extract(input logic [5:0] o, input logic [1:0] off,
                                                 input logic [31:0] r0, input logic [31:0] r1);
        logic [63:0] sh;
        sh = {r1, r0} >> {off, 3'b000};
        case (o)
            OP_LB:   load_extract = {{24{sh[7]}}, sh[7:0]};
            OP_LH:   load_extract = {{16{sh[15]}}, sh[15:0]};
            OP_LBU:  load_extract = {24'd0, sh[7:0]};
            OP_LHU:  load_extract = {16'd0, sh[15:0]};
            default: load_extract = sh[31:0];
        endcase
    endfunction

    state_t      state, state_next;
    logic [5:0]  op_r;
    logic [31:0] addr_r, wdata_r, rdata0, rdata1;
    logic        err_r;
    logic        live;
    logic [31:0] cnt;

    logic [1:0]  off_r;
    logic [2:0]  size_r;
    logic        store_r;
    logic [7:0]  lane_mask;
    logic        crossing_r;
    logic        accept, bad_op, misalign, tmo_hit;

    assign off_r     = addr_r[1:0];
    assign size_r    = op_size(op_r);
    assign store_r   = (op_r >= OP_SB);
    assign lane_mask = {4'b0000, size_mask(size_r)} << off_r;
    assign accept    = in_valid && (state == IDLE);
    assign bad_op    = (op < OP_LB) || (op > OP_SW);
    assign tmo_hit   = TMO_EN && (cnt == TMO_LAST);

`ifdef LSU_MISALIGN_SPLIT_EN
    assign crossing_r = (({1'b0, off_r} + size_r) > 3'd4);
    assign misalign   = 1'b0;
`else
    assign crossing_r = 1'b0;
    assign misalign   = ((op_size(op) == 3'd2) && addr[0]) ||
                        ((op_size(op) == 3'd4) && (addr[1:0] != 2'b00));
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Ack is checked before timeout so a same-cycle ack completes the access.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (bad_op || misalign) ? RESP : ACC0;
            ACC0: begin
                if (mem_ack)      state_next = crossing_r ? ACC1 : RESP;
                else if (tmo_hit) state_next = RESP;
            end
            ACC1: if (live && (mem_ack || tmo_hit)) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == RESP);
        out_err   = (state == RESP) && err_r;
        out_data  = 32'd0;
        mem_req   = 1'b0;
        mem_addr  = 32'd0;
        mem_we    = 4'b0000;
        mem_wdata = 32'd0;
        case (state)
            ACC0: begin
                mem_req  = 1'b1;
                mem_addr = {addr_r[31:2], 2'b00};
                if (store_r) begin
                    mem_we    = lane_mask[3:0];
                    mem_wdata = wdata_r << {off_r, 3'b000};
                end
            end
            ACC1: begin
                mem_req  = live;
                mem_addr = {addr_r[31:2], 2'b00} + 32'd4;
                if (store_r) begin
                    mem_we    = lane_mask[7:4];
                    mem_wdata = wdata_r >> {3'd4 - {1'b0, off_r}, 3'b000};
                end
            end
            RESP: begin
                if (!err_r && !store_r) out_data = load_extract(op_r, off_r, rdata0, rdata1);
            end
            default: ;
        endcase
    end

    // Control state: error flag, ACC1 request gap and the timeout counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_r <= 1'b0;
            live  <= 1'b0;
            cnt   <= 32'd0;
        end else begin
            live <= (state == ACC1);
            if (state_next != state)     cnt <= 32'd0;
            else if (mem_req && !mem_ack) cnt <= cnt + 32'd1;
            case (state)
                IDLE: if (accept) err_r <= bad_op || misalign;
                ACC0: if (!mem_ack && tmo_hit) err_r <= 1'b1;
                ACC1: if (live && !mem_ack && tmo_hit) err_r <= 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_r    <= op;
            addr_r  <= addr;
            wdata_r <= wdata;
        end
        if (state == ACC0 && mem_ack)         rdata0 <= mem_rdata;
        if (state == ACC1 && live && mem_ack) rdata1 <= mem_rdata;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: loads, stores, alignment errors, timeout and reset abort.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .addr(addr), .wdata(wdata),
        .out_valid(out_valid), .out_data(out_data), .out_err(out_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        op = o; addr = a; wdata = d; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a request, hold ack low for wait_cyc cycles, then ack once.
    task automatic mem_xfer(input string tag, input int wait_cyc, input logic [31:0] rd,
                            output logic [31:0] a, output logic [3:0] we,
                            output logic [31:0] wd, output int req_cycles);
        int n = 0;
        while (!mem_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        a = mem_addr; we = mem_we; wd = mem_wdata; req_cycles = 0;
        for (int i = 0; i < wait_cyc; i++) begin
            req_cycles += int'(mem_req);
            @(negedge clk);
        end
        req_cycles += int'(mem_req);
        mem_ack = 1'b1; mem_rdata = rd;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'd0;
    endtask

    task automatic resp_check(input string tag, input logic [31:0] exp_data, input logic exp_err);
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, out_data, exp_data);
        chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(out_valid), 32'd0);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    task automatic do_load(input string tag, input logic [5:0] o, input logic [31:0] a,
                           input logic [31:0] rd, input logic [31:0] exp_addr,
                           input logic [31:0] exp_data);
        logic [31:0] ma, mwd;
        logic [3:0]  mwe;
        int rc;
        issue(o, a, 32'd0);
        mem_xfer(tag, 0, rd, ma, mwe, mwd, rc);
        chk({tag, "_addr"}, ma, exp_addr);
        chk({tag, "_we"}, 32'(mwe), 32'd0);
        chk({tag, "_reqcyc"}, 32'(rc), 32'd1);
        resp_check(tag, exp_data, 1'b0);
    endtask

    task automatic do_reject(input string tag, input logic [5:0] o, input logic [31:0] a);
        issue(o, a, 32'hFFFF_FFFF);
        chk({tag, "_noreq"}, 32'(mem_req), 32'd0);
        resp_check(tag, 32'd0, 1'b1);
    endtask

    initial begin
        logic [31:0] ma, mwd;
        logic [3:0]  mwe;
        int rc, n, nv;

        reset_n = 1'b0; in_valid = 1'b0; op = 6'd0; addr = 32'd0; wdata = 32'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        @(negedge clk); @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        reset_n = 1'b1;

        do_load("lw", 6'd21, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 32'hDEAD_BEEF);
        do_load("lb", 6'd19, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0100, 32'hFFFF_FF80);
        do_load("lbu", 6'd22, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0100, 32'h0000_0080);
        do_load("lh", 6'd20, 32'h0000_0102, 32'h8001_1234, 32'h0000_0100, 32'hFFFF_8001);
        do_load("lhu", 6'd23, 32'h0000_0102, 32'h8001_1234, 32'h0000_0100, 32'h0000_8001);

        // Ack lands on the last timeout cycle: the ack must win.
        issue(6'd25, 32'h0000_0202, 32'h0000_ABCD);
        mem_xfer("sh", 3, 32'd0, ma, mwe, mwd, rc);
        chk("sh_addr", ma, 32'h0000_0200);
        chk("sh_we", 32'(mwe), 32'h0000_000C);
        chk("sh_wdata", mwd, 32'hABCD_0000);
        chk("sh_reqcyc", 32'(rc), 32'd4);
        resp_check("sh", 32'd0, 1'b0);

        issue(6'd24, 32'h0000_0201, 32'h1234_5678);
        mem_xfer("sb", 0, 32'd0, ma, mwe, mwd, rc);
        chk("sb_we", 32'(mwe), 32'h0000_0002);
        chk("sb_wdata", mwd, 32'h3456_7800);
        resp_check("sb", 32'd0, 1'b0);

        do_reject("badop", 6'd5, 32'h0000_0100);
        do_reject("badop27", 6'd27, 32'h0000_0100);

`ifdef LSU_MISALIGN_SPLIT_EN
        do_load("lh_mis", 6'd20, 32'h0000_0101, 32'h00AB_CD00, 32'h0000_0100, 32'hFFFF_ABCD);

        issue(6'd21, 32'h0000_0103, 32'd0);
        mem_xfer("lwx0", 0, 32'h4433_2211, ma, mwe, mwd, rc);
        chk("lwx0_addr", ma, 32'h0000_0100);
        chk("lwx_gap", 32'(mem_req), 32'd0);
        mem_xfer("lwx1", 0, 32'h8877_6655, ma, mwe, mwd, rc);
        chk("lwx1_addr", ma, 32'h0000_0104);
        resp_check("lwx", 32'h7766_5544, 1'b0);

        issue(6'd26, 32'h0000_0103, 32'hA1B2_C3D4);
        mem_xfer("swx0", 0, 32'd0, ma, mwe, mwd, rc);
        chk("swx0_we", 32'(mwe), 32'h0000_0008);
        chk("swx0_wdata", mwd, 32'hD400_0000);
        mem_xfer("swx1", 0, 32'd0, ma, mwe, mwd, rc);
        chk("swx1_addr", ma, 32'h0000_0104);
        chk("swx1_we", 32'(mwe), 32'h0000_0007);
        chk("swx1_wdata", mwd, 32'h00A1_B2C3);
        resp_check("swx", 32'd0, 1'b0);
`else
        do_reject("lh_mis", 6'd20, 32'h0000_0101);
        do_reject("lw_mis", 6'd21, 32'h0000_0102);
        do_reject("sw_mis", 6'd26, 32'h0000_0103);
`endif

        // No ack at all: request must be held exactly TIMEOUT cycles.
        issue(6'd21, 32'h0000_0300, 32'd0);
        n = 0; rc = 0;
        while (!out_valid && n < 12) begin
            rc += int'(mem_req);
            @(negedge clk);
            n++;
        end
        chk("tmo_reqcyc", 32'(rc), 32'd4);
        resp_check("tmo", 32'd0, 1'b1);

        issue(6'd21, 32'h0000_0400, 32'd0);
        chk("rstmid_req0", 32'(mem_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid_req", 32'(mem_req), 32'd0);
        chk("rstmid_rdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            nv += int'(out_valid);
            @(negedge clk);
        end
        chk("rstmid_novld", 32'(nv), 32'd0);

        do_load("lw_after", 6'd21, 32'h0000_0500, 32'h0102_0304, 32'h0000_0500, 32'h0102_0304);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

endmodule
